// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment encodings and digit type for the 7-segment scan driver
// Contents: digit_t (4-bit BCD digit), seg_t ({g,f,e,d,c,b,a}), SEG_0..SEG_9, SEG_DASH, SEG_BLANK.
package seg7_pkg;

  typedef logic [3:0] digit_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b0111111;
  localparam seg_t SEG_1     = 7'b0000110;
  localparam seg_t SEG_2     = 7'b1011011;
  localparam seg_t SEG_3     = 7'b1001111;
  localparam seg_t SEG_4     = 7'b1100110;
  localparam seg_t SEG_5     = 7'b1101101;
  localparam seg_t SEG_6     = 7'b1111101;
  localparam seg_t SEG_7     = 7'b0000111;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1101111;
  localparam seg_t SEG_DASH  = 7'b1000000;
  localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_encode.sv
// rtl/seg7_encode.sv - combinational BCD digit to 7-segment encoder
// Ports: digit (in, 4) BCD code; seg (out, 7) active-high {g,f,e,d,c,b,a}; codes 10..15 give a dash.
module seg7_encode
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    case (digit_t'(digit))
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed 7-segment scan driver with frame-synchronous display update
// Ports: clk, rst_n (async active-low); load + bcd_in (4*NUM_DIGITS) request an update;
//        blank_lz enables leading-zero blanking; ready high when no update pending;
//        seg (7) {g,f,e,d,c,b,a} and an (NUM_DIGITS, one-hot) registered outputs.
// Option: define SEG7_DP_EN to add dp_in (NUM_DIGITS) and dp (1) decimal-point handling.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int PRESCALE       = 1000,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    blank_lz,
`ifdef SEG7_DP_EN
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    dp,
`endif
  output logic                    ready,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int   CNT_W = $clog2(PRESCALE);
  localparam int   IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic INV   = (SEG_ACTIVE_LOW != 0);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic                    pending_q, pending_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic                    tick;
  logic                    frame_end;
  logic [NUM_DIGITS-1:0]   lz;
  logic                    lz_run;
  digit_t                  sel_digit;
  logic                    sel_lz;
  logic [6:0]              enc_seg;

`ifdef SEG7_DP_EN
  logic [NUM_DIGITS-1:0]   dp_disp_q, dp_disp_d;
  logic [NUM_DIGITS-1:0]   dp_shadow_q, dp_shadow_d;
  logic                    dp_q, dp_d;
  logic                    sel_dp;
`endif

  assign tick      = (cnt_q == CNT_W'(PRESCALE - 1));
  assign frame_end = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));

  // Prescaler and digit index.
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Updates land only on the frame boundary so a frame never mixes values.
  // A load on the boundary itself bypasses the shadow entirely.
  always_comb begin
    disp_d    = disp_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
`ifdef SEG7_DP_EN
    dp_disp_d   = dp_disp_q;
    dp_shadow_d = dp_shadow_q;
`endif
    if (frame_end) begin
      if (load) begin
        disp_d = bcd_in;
`ifdef SEG7_DP_EN
        dp_disp_d = dp_in;
`endif
      end else if (pending_q) begin
        disp_d = shadow_q;
`ifdef SEG7_DP_EN
        dp_disp_d = dp_shadow_q;
`endif
      end
      pending_d = 1'b0;
    end else if (load) begin
      shadow_d  = bcd_in;
      pending_d = 1'b1;
`ifdef SEG7_DP_EN
      dp_shadow_d = dp_in;
`endif
    end
  end

  // Leading-zero mask: a digit is blankable if it and every higher digit
  // is zero. Digit 0 always shows so a zero value still reads "0".
  always_comb begin
    lz     = '0;
    lz_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_run = lz_run && (disp_q[i*4 +: 4] == 4'd0);
      lz[i]  = lz_run && (i != 0);
    end
  end

  // Select the digit under the current index.
  always_comb begin
    sel_digit = '0;
    sel_lz    = 1'b0;
`ifdef SEG7_DP_EN
    sel_dp    = 1'b0;
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_digit = disp_q[i*4 +: 4];
        sel_lz    = lz[i];
`ifdef SEG7_DP_EN
        sel_dp    = dp_disp_q[i];
`endif
      end
    end
  end

  seg7_encode u_encode (
    .digit (sel_digit),
    .seg   (enc_seg)
  );

  always_comb begin
    seg_d = (blank_lz && sel_lz) ? SEG_BLANK : enc_seg;
    an_d  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_d[i] = (idx_q == IDX_W'(i));
    end
`ifdef SEG7_DP_EN
    // Decimal point is independent of blanking.
    dp_d = sel_dp;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      disp_q    <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      seg_q     <= '0;
      an_q      <= '0;
`ifdef SEG7_DP_EN
      dp_disp_q   <= '0;
      dp_shadow_q <= '0;
      dp_q        <= 1'b0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
`ifdef SEG7_DP_EN
      dp_disp_q   <= dp_disp_d;
      dp_shadow_q <= dp_shadow_d;
      dp_q        <= dp_d;
`endif
    end
  end

  assign ready = ~pending_q;
  assign seg   = INV ? ~seg_q : seg_q;
  assign an    = INV ? ~an_q : an_q;
`ifdef SEG7_DP_EN
  assign dp    = INV ? ~dp_q : dp_q;
`endif

endmodule
